// File: rtl/vector_mem_access_unit_if.sv
// Command, load-row, store-row and banked-memory signals of the vector
// memory access unit. "slave" is the unit itself; "master" is everything
// around it (SIMD controller, register file and vector_memory).
interface vector_mem_access_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_ELEM   = 64,
  parameter int CNT_WIDTH  = 8
);
  // command
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_op;
  logic [ADDR_WIDTH-1:0]          cmd_base;
  logic [ADDR_WIDTH-1:0]          cmd_stride;
  logic [CNT_WIDTH-1:0]           cmd_count;
  logic [NUM_ELEM-1:0]            cmd_mask;
  // load / store row streams
  logic                           ld_valid;
  logic                           ld_ready;
  logic [DATA_WIDTH*NUM_ELEM-1:0] ld_data;
  logic                           st_valid;
  logic                           st_ready;
  logic [DATA_WIDTH*NUM_ELEM-1:0] st_data;
  // banked memory ports
  logic [NUM_ELEM-1:0]            mem_read_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_read_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] mem_read_data;
  logic [NUM_ELEM-1:0]            mem_write_req;
  logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_write_addr;
  logic [DATA_WIDTH*NUM_ELEM-1:0] mem_write_data;
  // status
  logic                           busy;
  logic                           done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_count, cmd_mask,
    input  ld_ready, st_valid, st_data, mem_read_data,
    output cmd_ready, ld_valid, ld_data, st_ready,
    output mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
    output busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_stride, cmd_count, cmd_mask,
    output ld_ready, st_valid, st_data, mem_read_data,
    input  cmd_ready, ld_valid, ld_data, st_ready,
    input  mem_read_req, mem_read_addr, mem_write_req, mem_write_addr, mem_write_data,
    input  busy, done
  );
endinterface

// File: rtl/vector_mem_access_unit.sv
// Vector memory access unit: sequences one strided load/store command into
// per-row, per-lane requests on the banked memory. Lane i talks to bank i and
// every lane of a row uses the same address (base + row*stride).
module vector_mem_access_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_ELEM   = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  vector_mem_access_unit_if.slave bus
);
  localparam int ROW_W = DATA_WIDTH * NUM_ELEM;

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_reg, stride_reg;
  logic [CNT_WIDTH-1:0]   rows_left;
  logic [NUM_ELEM-1:0]    mask_reg;
  logic [1:0][ROW_W-1:0]  fifo_q;
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             fifo_cnt;
  logic                   inflight;
  logic                   done_q;

  logic                   cmd_fire, issue_rd, issue_wr, pop, done_set;
  logic [1:0]             occ;
  logic [ROW_W-1:0]       push_row;

  // Returning read data: disabled lanes are forced to zero before the FIFO.
  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_lane
    assign push_row[i*DATA_WIDTH +: DATA_WIDTH] =
      mask_reg[i] ? bus.mem_read_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  // Next-state and per-cycle issue decisions.
  // Occupancy counts a pop happening this cycle as already freed, so a
  // 2-entry FIFO sustains one row per cycle while ld_ready stays high.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    pop       = (fifo_cnt != 2'd0) && bus.ld_ready;
    occ       = fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    cmd_fire  = bus.cmd_valid && (state == IDLE);
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (bus.cmd_count == '0) done_set  = 1'b1;
          else                     state_nxt = bus.cmd_op ? STORE : LOAD;
        end
      end
      LOAD: begin
        if ((rows_left != '0) && (occ < 2'd2)) begin
          issue_rd = 1'b1;
          if (rows_left == CNT_WIDTH'(1)) state_nxt = DRAIN;
        end
      end
      STORE: begin
        if (bus.st_valid) begin
          issue_wr = 1'b1;
          if (rows_left == CNT_WIDTH'(1)) begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end
        end
      end
      DRAIN: begin
        // finish as soon as the FIFO will be empty after this cycle
        if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Command latch, row address/counter, in-flight flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg   <= '0;
      stride_reg <= '0;
      rows_left  <= '0;
      mask_reg   <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      done_q   <= done_set;
      inflight <= issue_rd;
      if (cmd_fire) begin
        addr_reg   <= bus.cmd_base;
        stride_reg <= bus.cmd_stride;
        rows_left  <= bus.cmd_count;
        mask_reg   <= bus.cmd_mask;
      end else if (issue_rd || issue_wr) begin
        addr_reg  <= addr_reg + stride_reg;  // wraps modulo 2^ADDR_WIDTH
        rows_left <= rows_left - CNT_WIDTH'(1);
      end
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // FIFO storage; contents are don't-care while fifo_cnt is zero, so no reset.
  always_ff @(posedge clk) begin
    if (inflight) fifo_q[wr_ptr] <= push_row;
  end

  assign bus.cmd_ready      = (state == IDLE);
  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;
  assign bus.ld_valid       = (fifo_cnt != 2'd0);
  assign bus.ld_data        = fifo_q[rd_ptr];
  assign bus.st_ready       = (state == STORE);
  assign bus.mem_read_req   = issue_rd ? mask_reg : '0;
  assign bus.mem_write_req  = issue_wr ? mask_reg : '0;
  assign bus.mem_read_addr  = {NUM_ELEM{addr_reg}};
  assign bus.mem_write_addr = {NUM_ELEM{addr_reg}};
  assign bus.mem_write_data = bus.st_data;
endmodule
